// File: rtl/dm_pkg.sv
// dm_pkg: shared definitions for the data-memory responder.
//   - DMType access codes as driven by the core's MEM stage
//   - FSM state encoding (IDLE, ACC0, ACC1, RESP)
//   - dm_size(): access size in bytes for a DMType (0 for illegal codes)
package dm_pkg;

  typedef enum logic [2:0] {
    dm_word              = 3'b000,
    dm_halfword          = 3'b001,
    dm_halfword_unsigned = 3'b010,
    dm_byte              = 3'b011,
    dm_byte_unsigned     = 3'b100
  } dm_type_e;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC0 = 2'd1;
  localparam logic [1:0] ACC1 = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  function automatic logic [2:0] dm_size(input logic [2:0] dmtype);
    case (dmtype)
      dm_word:                          dm_size = 3'd4;
      dm_halfword, dm_halfword_unsigned: dm_size = 3'd2;
      dm_byte, dm_byte_unsigned:         dm_size = 3'd1;
      default:                          dm_size = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// dm_lane_align: combinational byte-lane steering shared by store and load paths.
// Ports:
//   offset  in  2   byte offset within the first word
//   dmtype  in  3   access type
//   wdata   in  32  right-aligned store data
//   rd_lo   in  32  first (lower-address) word read
//   rd_hi   in  32  second word read (0 when the access is not split)
//   wr_lo   out 32  store data for the first word
//   wr_hi   out 32  store data for the second word
//   be      out 8   byte enables; [3:0] first word, [7:4] second word
//   rdata   out 32  extracted, sign/zero-extended load result
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [2:0]  dmtype,
  input  logic [31:0] wdata,
  input  logic [31:0] rd_lo,
  input  logic [31:0] rd_hi,
  output logic [31:0] wr_lo,
  output logic [31:0] wr_hi,
  output logic [7:0]  be,
  output logic [31:0] rdata
);

  logic [4:0]  shamt;
  logic [63:0] wr_wide;
  logic [63:0] rd_wide;
  logic [31:0] rd_word;
  logic [7:0]  be_base;

  assign shamt = {offset, 3'b000};

  // Store: shift the 64-bit {0, wdata} window up to the byte offset.
  assign wr_wide = {32'b0, wdata} << shamt;
  assign wr_lo   = wr_wide[31:0];
  assign wr_hi   = wr_wide[63:32];

  always_comb begin
    be_base = 8'h00;
    case (dm_size(dmtype))
      3'd4:    be_base = 8'h0f;
      3'd2:    be_base = 8'h03;
      3'd1:    be_base = 8'h01;
      default: be_base = 8'h00;
    endcase
  end

  assign be = be_base << offset;

  // Load: shift the two-word window down, then truncate and extend.
  assign rd_wide = {rd_hi, rd_lo} >> shamt;
  assign rd_word = rd_wide[31:0];

  always_comb begin
    rdata = 32'h0;
    case (dmtype)
      dm_word:              rdata = rd_word;
      dm_halfword:          rdata = {{16{rd_word[15]}}, rd_word[15:0]};
      dm_halfword_unsigned: rdata = {16'h0, rd_word[15:0]};
      dm_byte:              rdata = {{24{rd_word[7]}}, rd_word[7:0]};
      dm_byte_unsigned:     rdata = {24'h0, rd_word[7:0]};
      default:              rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/dm_ctrl.sv
// dm_ctrl: data-memory responder for the core's MEM stage.
// Holds a 2^ADDR_W x 32-bit byte-enabled array; misaligned accesses crossing a
// word boundary are split into two word accesses (ACC0, ACC1).
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake (ready only in IDLE)
//   req_we               1 = store, 0 = load
//   req_addr             byte address
//   req_wdata            right-aligned store data
//   req_dmtype           access type
//   rsp_valid            one-cycle completion pulse
//   rsp_rdata            load result (0 for stores/errors), held until next response
//   rsp_err              out-of-range address or illegal dmtype
module dm_ctrl
  import dm_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_dmtype,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [31:0] mem [Depth];

  logic [1:0]        state_q, state_d;
  logic              we_q;
  logic [1:0]        off_q;
  logic [ADDR_W-1:0] idx_q;
  logic [2:0]        dmtype_q;
  logic [31:0]       wdata_q;
  logic              split_q;
  logic [31:0]       lo_q;
  logic [31:0]       rsp_rdata_q;
  logic              rsp_err_q;

  logic              accept;
  logic              req_err;
  logic              req_split;
  logic              finish;
  logic [ADDR_W-1:0] rd_idx;
  logic [31:0]       rd_word;
  logic [31:0]       al_lo, al_hi;
  logic [31:0]       wr_lo, wr_hi;
  logic [7:0]        be;
  logic [31:0]       ld_data;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wd;

  assign req_err   = (req_addr[31:ADDR_W+2] != '0) || (req_dmtype > 3'd4);
  assign req_split = ({1'b0, req_addr[1:0]} + dm_size(req_dmtype)) > 3'd4;

  // ACC1 addresses the next word; the increment wraps at the top of memory.
  assign rd_idx  = (state_q == ACC1) ? idx_q + ADDR_W'(1) : idx_q;
  assign rd_word = mem[rd_idx];

  // In ACC0 the live read is the low word; in ACC1 the low word was latched.
  assign al_lo = (state_q == ACC1) ? lo_q : rd_word;
  assign al_hi = (state_q == ACC1) ? rd_word : 32'h0;

  dm_lane_align u_align (
    .offset (off_q),
    .dmtype (dmtype_q),
    .wdata  (wdata_q),
    .rd_lo  (al_lo),
    .rd_hi  (al_hi),
    .wr_lo  (wr_lo),
    .wr_hi  (wr_hi),
    .be     (be),
    .rdata  (ld_data)
  );

  assign mem_we = we_q && ((state_q == ACC0) || (state_q == ACC1));
  assign mem_be = (state_q == ACC1) ? be[7:4] : be[3:0];
  assign mem_wd = (state_q == ACC1) ? wr_hi : wr_lo;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem[rd_idx][8*b +: 8] <= mem_wd[8*b +: 8];
      end
    end
  end

  // Last array cycle of a non-error access: result is ready to register.
  assign finish = ((state_q == ACC0) && !split_q) || (state_q == ACC1);
  assign accept = (state_q == IDLE) && req_valid;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid) state_d = req_err ? RESP : ACC0;
      ACC0:    state_d = split_q ? ACC1 : RESP;
      ACC1:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      off_q       <= 2'b0;
      idx_q       <= '0;
      dmtype_q    <= 3'b0;
      wdata_q     <= 32'h0;
      split_q     <= 1'b0;
      lo_q        <= 32'h0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q     <= req_we;
        off_q    <= req_addr[1:0];
        idx_q    <= req_addr[ADDR_W+1:2];
        dmtype_q <= req_dmtype;
        wdata_q  <= req_wdata;
        split_q  <= req_split;
        if (req_err) begin
          rsp_rdata_q <= 32'h0;
          rsp_err_q   <= 1'b1;
        end
      end
      if ((state_q == ACC0) && split_q) lo_q <= rd_word;
      if (finish) begin
        rsp_rdata_q <= we_q ? 32'h0 : ld_data;
        rsp_err_q   <= 1'b0;
      end
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dm_ctrl.sv
// tb_dm_ctrl: scoreboard bench for dm_ctrl. The driver pushes the expected
// response (data, error, due cycle) on each accepted request; a monitor pops
// and compares whenever rsp_valid is seen.
module tb_dm_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_dmtype;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  dm_ctrl #(.ADDR_W(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_dmtype (req_dmtype),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  typedef struct {
    int          tag;
    logic [31:0] rd;
    logic        err;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   tag_n = 0;
  bit   chk_after = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      if (chk_after) begin
        check("ready_after_rsp", {30'b0, req_ready, rsp_valid}, 32'h2);
        chk_after = 0;
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 32'h1, 32'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check($sformatf("rdata#%0d", e.tag), rsp_rdata, e.rd);
          check($sformatf("err#%0d", e.tag), {31'b0, rsp_err}, {31'b0, e.err});
          check($sformatf("latency#%0d", e.tag), cyc, e.due);
        end
        chk_after = 1;
      end
    end
  end

  // Drive a request until accepted; lat is the accept-to-rsp_valid distance.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] dt, input logic [31:0] exp_rd, input logic exp_err,
                       input int lat, input bit track);
    int n;
    exp_t e;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    req_dmtype = dt;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("accept_timeout", 32'h0, 32'h1);
      req_valid = 1'b0;
      return;
    end
    tag_n++;
    if (track) begin
      e.tag = tag_n;
      e.rd  = exp_rd;
      e.err = exp_err;
      e.due = cyc + lat;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    // Junk on ignored inputs: a store of 0 to 0x10 if the DUT wrongly took it.
    req_valid  = 1'b0;
    req_we     = 1'b1;
    req_addr   = 32'h10;
    req_wdata  = 32'h0;
    req_dmtype = 3'b000;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 32'h0);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    req_dmtype = 3'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'h1);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_err", {31'b0, rsp_err}, 32'h0);
    rst = 1'b1;

    // we, addr, wdata, dmtype, expected rdata, err, latency, tracked
    issue(1, 32'h10, 32'hDEADBEEF, 3'd0, 32'h0, 0, 2, 1);
    issue(0, 32'h10, 32'h0, 3'd0, 32'hDEADBEEF, 0, 2, 1);
    issue(0, 32'h10, 32'h0, 3'd1, 32'hFFFFBEEF, 0, 2, 1);
    issue(0, 32'h12, 32'h0, 3'd2, 32'h0000DEAD, 0, 2, 1);

    issue(1, 32'h20, 32'h11223344, 3'd0, 32'h0, 0, 2, 1);
    issue(1, 32'h21, 32'hFFFFFFAA, 3'd3, 32'h0, 0, 2, 1);
    issue(0, 32'h20, 32'h0, 3'd0, 32'h1122AA44, 0, 2, 1);
    issue(0, 32'h21, 32'h0, 3'd3, 32'hFFFFFFAA, 0, 2, 1);
    issue(0, 32'h21, 32'h0, 3'd4, 32'h000000AA, 0, 2, 1);

    issue(1, 32'h30, 32'h0, 3'd0, 32'h0, 0, 2, 1);
    issue(1, 32'h34, 32'h0, 3'd0, 32'h0, 0, 2, 1);
    issue(1, 32'h33, 32'hCAFEBABE, 3'd0, 32'h0, 0, 3, 1);
    issue(0, 32'h30, 32'h0, 3'd0, 32'hBE000000, 0, 2, 1);
    issue(0, 32'h34, 32'h0, 3'd0, 32'h00CAFEBA, 0, 2, 1);
    issue(0, 32'h33, 32'h0, 3'd0, 32'hCAFEBABE, 0, 3, 1);

    // Top-of-memory wrap: 0xFFF and 0x000 are the two halves.
    issue(1, 32'hFFF, 32'h00008001, 3'd1, 32'h0, 0, 3, 1);
    issue(0, 32'hFFF, 32'h0, 3'd4, 32'h00000001, 0, 2, 1);
    issue(0, 32'h000, 32'h0, 3'd4, 32'h00000080, 0, 2, 1);
    issue(0, 32'hFFF, 32'h0, 3'd1, 32'hFFFF8001, 0, 3, 1);

    issue(0, 32'h00001000, 32'h0, 3'd0, 32'h0, 1, 1, 1);
    issue(1, 32'h00001010, 32'h12345678, 3'd0, 32'h0, 1, 1, 1);
    issue(0, 32'h10, 32'h0, 3'd7, 32'h0, 1, 1, 1);
    issue(0, 32'h10, 32'h0, 3'd5, 32'h0, 1, 1, 1);
    issue(0, 32'h10, 32'h0, 3'd0, 32'hDEADBEEF, 0, 2, 1);

    // Reset during ACC1 of a split store.
    issue(1, 32'h40, 32'h11111111, 3'd0, 32'h0, 0, 2, 1);
    issue(1, 32'h44, 32'h22222222, 3'd0, 32'h0, 0, 2, 1);
    issue(0, 32'h44, 32'h0, 3'd0, 32'h22222222, 0, 2, 1);
    drain();
    issue(1, 32'h42, 32'hAABBCCDD, 3'd0, 32'h0, 0, 3, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_ready", {31'b0, req_ready}, 32'h1);
    check("midrst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("midrst_rdata", rsp_rdata, 32'h0);
    check("midrst_err", {31'b0, rsp_err}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    issue(0, 32'h40, 32'h0, 3'd0, 32'hCCDD1111, 0, 2, 1);
    issue(0, 32'h44, 32'h0, 3'd0, 32'h22222222, 0, 2, 1);
    issue(0, 32'h42, 32'h0, 3'd1, 32'hFFFFCCDD, 0, 2, 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dm_ctrl.md
# dm_ctrl

Data-memory responder for the pipelined RISC-V core: it serves the load/store requests the core's MEM stage issues (address, store data, write enable, DMType) and returns load data or store completion. It owns a word-organised byte-enabled storage array. Misaligned halfword/word accesses are split into two word accesses by an internal state machine. It sits on the core's data side and stalls the MEM stage through a valid/ready handshake.

## Interface
- ADDR_W, 10: word-address width; storage depth is 2^ADDR_W 32-bit words, byte range 0 .. 4·2^ADDR_W−1.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- req_dmtype  in  3  access type: 000 word, 001 half, 010 half unsigned, 011 byte, 100 byte unsigned.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  load result, sign/zero extended; 0 for stores and errors.
- rsp_err  out  1  valid with rsp_valid: address out of range or illegal dmtype.

## Operation
- Handshake: request accepted on a cycle with req_valid && req_ready; all request fields are captured then. Request inputs are ignored in every other cycle.
- States:
  - IDLE → ACC0 on accept.
  - ACC0 → ACC1 if the access is split, else → RESP.
  - ACC1 → RESP.
  - RESP → IDLE.
  - IDLE → RESP directly on accept when an error is detected.
- Access geometry:
  - Size: 4, 2 or 1 bytes from dmtype.
  - Offset: addr[1:0]; word index: addr[ADDR_W+1:2].
  - A request is split when offset + size > 4.
  - The second word index is (index+1) mod 2^ADDR_W, so it wraps to word 0 at the top of memory.
- Error: addr[31:ADDR_W+2] ≠ 0, or dmtype ∈ {101, 110, 111}. No array access is made; rsp_rdata = 0, rsp_err = 1.
- Store:
  - The {32'b0, wdata} value is shifted left by offset·8 into 64 bits; byte enables follow the same shift.
  - ACC0 writes the low word with its enables; ACC1 writes the high word with its enables.
  - Only the enabled bytes change.
- Load:
  - ACC0 latches the low word; ACC1 latches the high word (0 if not split).
  - The result is {hi, lo} >> offset·8, truncated to size.
  - Sign-extended for 001/011, zero-extended for 010/100.
- Storage contents are not reset.

## Timing
- Reset values: req_ready = 1 (state IDLE), rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
- Request accepted at cycle T:
  - Aligned access: array access in T+1, rsp_valid in T+2, req_ready high again in T+3.
  - Split access: array accesses in T+1 and T+2, rsp_valid in T+3, req_ready high in T+4.
  - Error: rsp_valid in T+1, req_ready high in T+2.
- rsp_rdata and rsp_err are registered and change only when rsp_valid rises. They hold their value until the next response.
- There is no response backpressure; the requester must sample rsp_valid.
- Back-to-back: a request held valid across RESP is accepted in the first IDLE cycle.
- Reset mid-operation: state returns to IDLE immediately. A split store interrupted after ACC0 keeps its low-word write; there is no rollback. No response is issued.
- Load following a store to the same bytes returns the new data (stores complete before RESP).

## Structure
- Package dm_pkg holds:
  - DMType codes: dm_word, dm_halfword, dm_halfword_unsigned, dm_byte, dm_byte_unsigned.
  - State encoding: IDLE, ACC0, ACC1, RESP.
  - A size-from-dmtype function.
- Sub-module dm_lane_align: purely combinational. Produces store shift plus 8-bit byte enables, and load extract/extend from {hi, lo}, offset and dmtype. It is shared by the store and load paths.
- The storage array and FSM live in dm_ctrl.

## Test plan
- Word store then word load at 0x10: store 0xDEADBEEF → rsp_valid at T+2, rdata 0; load → rdata 0xDEADBEEF, err 0.
- Byte lanes at 0x20 after word 0x11223344 stored:
  - Store byte 0xAA at 0x21, then word load → 0x1122AA44.
  - Load byte at 0x21 → 0xFFFFFFAA.
  - Load byte unsigned at 0x21 → 0x000000AA.
- Split word store 0xCAFEBABE at 0x33 → rsp_valid at T+3. Word load at 0x30 → 0xBEXXXXXX in the top byte (0xBE at [31:24]); word load at 0x34 → low 3 bytes 0xCAFEBA. Misaligned word load at 0x33 → 0xCAFEBABE.
- Wrap: with ADDR_W = 10, store half 0x8001 at 0xFFF → byte 0xFFF = 0x01, byte 0x000 = 0x80. Half load at 0xFFF → 0xFFFF8001.
- Errors:
  - Load at 0x00001000 → rsp_valid at T+1, err 1, rdata 0, memory unchanged.
  - dmtype 111 → err 1.
- Reset asserted during ACC1 of a split store → outputs at reset values, no rsp_valid. Only the low word was modified; the next request is accepted normally.
